// File: rtl/cic_interp.sv
// cic_interp: cascaded integrator-comb interpolator for the transmit path.
// The comb chain runs at the low rate and is clocked by strobe_in. The integrator
// chain runs at the high rate and is clocked by strobe_out. Zero-stuffing happens
// between the two chains. The CIC gain is removed with a rate-dependent
// arithmetic right shift before the result is truncated to bitwidth.
module cic_interp #(
  parameter int bitwidth = 16,
  parameter int stages   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          rate,
  input  logic                strobe_in,
  input  logic                strobe_out,
  input  logic [bitwidth-1:0] signal_in,
  output logic [bitwidth-1:0] signal_out
);

  // The accumulators have 8 bits of headroom per stage. This covers the worst
  // case growth for rate up to 255. All arithmetic wraps modulo 2^acc_w on
  // purpose.
  localparam int acc_w = bitwidth + 8 * stages;

  typedef logic signed [acc_w-1:0] acc_t;

  acc_t comb_z [stages];   // previous input of each comb stage
  acc_t comb_d [stages];   // registered output of each comb stage
  acc_t comb_x [stages];   // input of each comb stage
  acc_t integ  [stages];   // integrator accumulators
  acc_t inject;            // zero-stuffed sample fed to the first integrator

  logic [7:0]          rate_m1;
  logic [3:0]          log2_rate;
  logic [15:0]         shift_amt;
  logic [bitwidth-1:0] out_next;

  // Gain compensation: shift = (stages-1) * ceil_log2(rate). A rate of 0 is
  // handled the same as a rate of 1.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rate_m1   = (rate == 8'd0) ? 8'd0 : rate - 8'd1;
    log2_rate = 4'd0;
    for (int b = 0; b < 8; b++) begin
      if (rate_m1[b]) log2_rate = 4'(b + 1);
    end
    shift_amt = 16'(stages - 1) * 16'(log2_rate);
  end

  // Comb inputs: a sign-extended sample into stage 0, then the registered chain.
  always_comb begin
    comb_x[0] = acc_t'($signed(signal_in));
    for (int k = 1; k < stages; k++) begin
      comb_x[k] = comb_d[k-1];
    end
  end

  // Zero-stuffing injects the last comb output only on strobe_in cycles.
  // The scaled output is the arithmetic shift (floor) of the last integrator,
  // truncated to bitwidth.
  always_comb begin
    inject   = strobe_in ? comb_d[stages-1] : '0;
    out_next = bitwidth'(integ[stages-1] >>> shift_amt);
  end

  // Comb section: all stages advance together on strobe_in, as a registered chain.
  // NOTE: these delay arrays are cleared explicitly. Dropping enable must flush
  // every stage, so they are functional state and not plain storage.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      for (int k = 0; k < stages; k++) begin
        comb_z[k] <= '0;
        comb_d[k] <= '0;
      end
    end else if (strobe_in) begin
      for (int k = 0; k < stages; k++) begin
        comb_d[k] <= comb_x[k] - comb_z[k];
        comb_z[k] <= comb_x[k];
      end
    end
  end

  // Integrator section and output register: they advance together on strobe_out.
  // Each integrator reads the value its neighbour had before this edge.
  // NOTE: non-blocking assignments give every stage the pre-edge value of the
  // stage before it. Blocking assignments would collapse the chain into one cycle.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      for (int k = 0; k < stages; k++) begin
        integ[k] <= '0;
      end
      signal_out <= '0;
    end else if (strobe_out) begin
      integ[0] <= integ[0] + inject;
      for (int k = 1; k < stages; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      signal_out <= out_next;
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Directed testbench for cic_interp (bitwidth=16, stages=4).
// The expected values are worked out by hand from the CIC transfer function
// ((1 - z^-R) / (1 - z^-1))^N followed by a shift of (N-1)*ceil_log2(R).
module tb_cic_interp;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rate;
  logic        strobe_in;
  logic        strobe_out;
  logic [15:0] signal_in;
  logic [15:0] signal_out;

  int checks = 0;
  int errors = 0;

  // Response to a single input sample of 64 at R=4, N=4. The raw filter taps
  // are (1+z^-1+z^-2+z^-3)^4. The scaling is 64/2^6, so the output equals the
  // taps themselves.
  int h [13] = '{1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1};

  cic_interp #(.bitwidth(16), .stages(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .strobe_out (strobe_out),
    .signal_in  (signal_in),
    .signal_out (signal_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(observed), observed, $signed(expected), expected);
    end
  endtask

  // Apply the inputs for one cycle. The outputs are sampled 1 ns after the edge.
  task automatic tick(input logic si, input logic so, input logic [15:0] din);
    strobe_in  = si;
    strobe_out = so;
    signal_in  = din;
    @(posedge clock);
    #1;
  endtask

  // Cycle c=0 carries the sample 64, and strobe_in fires every 4th cycle. The
  // sample reaches int0 at edge 16 and signal_out at edge 20.
  task automatic run_impulse(input string tag);
    int expv;
    for (int c = 0; c <= 40; c++) begin
      tick(logic'(c % 4 == 0), 1'b1, (c == 0) ? 16'd64 : 16'd0);
      expv = (c >= 20 && c <= 32) ? h[c-20] : 0;
      check(tag, signal_out, 16'(expv));
    end
  endtask

  // Drive a constant input at ratio r for 64 cycles. Check the last 4 outputs.
  task automatic run_dc(input string tag, input int r, input logic [15:0] din,
                        input logic [15:0] expected);
    for (int c = 0; c < 64; c++) begin
      tick(logic'(c % r == 0), 1'b1, din);
      if (c >= 60) check(tag, signal_out, expected);
    end
  endtask

  initial begin
    int expv;
    int j;
    reset      = 1'b1;
    enable     = 1'b1;
    rate       = 8'd4;
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
    signal_in  = '0;

    // Reset is held with the strobes active and a full-scale input.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 16'h7fff);
      check("reset", signal_out, 16'h0000);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(logic'(i % 4 == 0), 1'b1, 16'h0000);
      check("post_reset_idle", signal_out, 16'h0000);
    end

    run_impulse("impulse");

    // Full-scale DC at R=4 has a net gain of exactly 1.
    run_dc("dc_7fff", 4, 16'h7fff, 16'h7fff);
    run_dc("dc_8000", 4, 16'h8000, 16'h8000);
    run_dc("dc_ffff", 4, 16'hffff, 16'hffff);

    // The rate changes only while enable is low. This also clears the output.
    enable = 1'b0;
    rate   = 8'd3;
    tick(1'b0, 1'b1, 16'h0000);
    check("disable_clear", signal_out, 16'h0000);
    enable = 1'b1;

    // R=3 gives shift=6. Each polyphase branch of (1+z^-1+z^-2)^4 sums to 27,
    // so the DC output is 64*27 >>> 6 = 27.
    run_dc("dc_rate3", 3, 16'd64, 16'd27);

    // Enable is dropped for one cycle mid-stream, then an impulse is applied.
    // The response must match the first impulse exactly, with no residue.
    enable = 1'b0;
    rate   = 8'd4;
    tick(1'b1, 1'b1, 16'h1234);
    check("enable_drop", signal_out, 16'h0000);
    enable = 1'b1;
    run_impulse("impulse_reenable");

    // Missed injection: at edge 16, strobe_in fires without strobe_out, so the
    // +64 comb output is dropped. The comb output for that injection, fed
    // through four integrators, would have added C(j+3,3) at output edge 20+j.
    // The remaining output is therefore h[j] - C(j+3,3).
    enable = 1'b0;
    tick(1'b0, 1'b1, 16'h0000);
    check("clear_before_missed", signal_out, 16'h0000);
    enable = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      tick(logic'(c % 4 == 0), logic'(c != 16), (c == 0) ? 16'd64 : 16'd0);
      if (c < 20) begin
        expv = 0;
      end else begin
        j    = c - 20;
        expv = ((j <= 12) ? h[j] : 0) - ((j + 3) * (j + 2) * (j + 1)) / 6;
      end
      check("missed_injection", signal_out, 16'(expv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
